// File: rtl/goertzel_tone_gen.sv
// Goertzel-style resonator producing a period-6 tone frame of N samples at amplitude A.
// One sample per accepted transfer; o_valid held with o_sample/o_last stable until i_ready.
module goertzel_tone_gen #(
    parameter int OW = 12,
    parameter int N  = 126
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [OW-2:0] i_amp,
    input  logic          i_cont,
    input  logic          i_ready,
    output logic [OW-1:0] o_sample,
    output logic          o_valid,
    output logic          o_last,
    output logic          o_busy,
    output logic          o_done
);

    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam logic [NW-1:0] LAST_IDX = NW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] samp_d;
    logic [OW-1:0] y_prev_q, y_prev_d;
    logic [NW-1:0] n_q, n_d;
    logic [OW-1:0] amp_ext;

    assign amp_ext = {1'b0, i_amp};

    always_comb begin
        state_d  = state_q;
        samp_d   = o_sample;
        y_prev_d = y_prev_q;
        n_d      = n_q;
        case (state_q)
            IDLE: begin
                samp_d   = '0;
                y_prev_d = '0;
                n_d      = '0;
                if (i_start) begin
                    state_d = RUN;
                    samp_d  = amp_ext;
                end
            end
            RUN: begin
                if (i_ready) begin
                    if (n_q == LAST_IDX) begin
                        y_prev_d = '0;
                        n_d      = '0;
                        if (i_cont) begin
                            samp_d = amp_ext;
                        end else begin
                            state_d = DONE;
                            samp_d  = '0;
                        end
                    end else begin
                        // Magnitudes never exceed A, so an OW-bit difference equals the truncated OW+1-bit one.
                        samp_d   = o_sample - y_prev_q;
                        y_prev_d = o_sample;
                        n_d      = n_q + NW'(1);
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                samp_d   = '0;
                y_prev_d = '0;
                n_d      = '0;
            end
            default: begin
                state_d  = IDLE;
                samp_d   = '0;
                y_prev_d = '0;
                n_d      = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            o_sample <= '0;
            y_prev_q <= '0;
            n_q      <= '0;
        end else begin
            state_q  <= state_d;
            o_sample <= samp_d;
            y_prev_q <= y_prev_d;
            n_q      <= n_d;
        end
    end

    assign o_valid = (state_q == RUN);
    assign o_busy  = (state_q == RUN);
    assign o_last  = (state_q == RUN) && (n_q == LAST_IDX);
    assign o_done  = (state_q == DONE);

endmodule

// File: tb/tb_goertzel_tone_gen.sv
// Randomized bench for goertzel_tone_gen against a frame-level reference model.
module tb_goertzel_tone_gen;

    localparam int OW = 12;
    localparam int N  = 126;

    logic          i_clk = 1'b0;
    logic          i_rst, i_start, i_cont, i_ready;
    logic [OW-2:0] i_amp;
    logic [OW-1:0] o_sample;
    logic          o_valid, o_last, o_busy, o_done;

    goertzel_tone_gen #(.OW(OW), .N(N)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_amp(i_amp),
        .i_cont(i_cont), .i_ready(i_ready), .o_sample(o_sample),
        .o_valid(o_valid), .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int errs = 0;
    int checks = 0;
    int nprint = 0;
    int done_cnt = 0;
    bit chk_en = 0;
    bit rnd_ready = 0, rnd_cont = 0, rnd_amp = 0, rnd_start = 0;
    integer xq[$];
    bit     lq[$];
    integer t1q[$];

    task automatic chk(input string nm, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errs++;
            if (nprint < 40) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
            nprint++;
        end
    endtask

    function automatic integer pat(input integer a, input integer k);
        case (k % 6)
            0, 1:    return a;
            3, 4:    return -a;
            default: return 0;
        endcase
    endfunction

    // Frame-level model: whether a frame is running, its amplitude and sample index.
    bit     m_run = 0, m_done = 0;
    integer m_amp = 0, m_idx = 0;

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_run = 0; m_done = 0; m_idx = 0; m_amp = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_run) begin
            if (i_start) begin
                m_run = 1; m_amp = int'(i_amp); m_idx = 0;
            end
        end else if (i_ready) begin
            if (m_idx == N - 1) begin
                if (i_cont) begin
                    m_amp = int'(i_amp); m_idx = 0;
                end else begin
                    m_run = 0; m_done = 1;
                end
            end else begin
                m_idx++;
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("valid", o_valid, m_run);
            chk("busy", o_busy, m_run);
            chk("last", o_last, (m_run && m_idx == N - 1) ? 1 : 0);
            chk("sample", $signed(o_sample), m_run ? pat(m_amp, m_idx) : 0);
            chk("done", o_done, m_done);
            if (o_done === 1'b1) done_cnt++;
            if (o_valid === 1'b1 && i_ready && !i_rst) begin
                xq.push_back($signed(o_sample));
                lq.push_back(o_last);
            end
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #2;
        if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
        if (rnd_cont)  i_cont  = ($urandom_range(0, 3) == 0);
        if (rnd_amp)   i_amp   = (OW-1)'($urandom_range(0, 2047));
        if (rnd_start) i_start = ($urandom_range(0, 7) == 0);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string nm);
        for (int i = 0; i < bound; i++) begin
            cyc();
            if (o_done === 1'b1) begin
                cyc();
                return;
            end
        end
        errs++; checks++;
        $display("FAIL %s: no o_done within %0d cycles", nm, bound);
    endtask

    task automatic wait_xfers(input int cnt, input int bound, input string nm);
        for (int i = 0; i < bound; i++) begin
            if (xq.size() >= cnt) return;
            cyc();
        end
        errs++; checks++;
        $display("FAIL %s: only %0d transfers, needed %0d", nm, xq.size(), cnt);
    endtask

    task automatic clear_q();
        xq.delete();
        lq.delete();
    endtask

    integer lit[6];
    int     d0, nlast, mx, mn;

    initial begin
        lit[0] = 100; lit[1] = 100; lit[2] = 0; lit[3] = -100; lit[4] = -100; lit[5] = 0;
        i_rst = 1; i_start = 0; i_cont = 0; i_ready = 1; i_amp = '0;
        cyc();
        chk_en = 1;
        cyc();
        i_rst = 0;
        chk("rst_valid", o_valid, 0);
        chk("rst_sample", $signed(o_sample), 0);
        cyc(); cyc();

        // Plain frame, A=100, always ready
        i_amp = 11'd100;
        d0 = done_cnt;
        pulse_start();
        wait_done(400, "t1_done");
        chk("t1_count", xq.size(), N);
        nlast = 0;
        foreach (lq[k]) nlast += lq[k];
        chk("t1_nlast", nlast, 1);
        if (xq.size() == N) begin
            chk("t1_last_pos", lq[N-1], 1);
            for (int k = 0; k < N; k++) chk("t1_seq", xq[k], lit[k % 6]);
        end
        chk("t1_done_cnt", done_cnt - d0, 1);
        t1q = xq;
        clear_q();

        // Same frame under random backpressure
        rnd_ready = 1;
        pulse_start();
        wait_done(3000, "t2_done");
        rnd_ready = 0; i_ready = 1;
        chk("t2_count", xq.size(), N);
        if (xq.size() == N && t1q.size() == N)
            for (int k = 0; k < N; k++) chk("t2_same", xq[k], t1q[k]);
        clear_q();

        // Continuous mode, amplitude change mid-frame
        i_amp = 11'd50; i_cont = 1;
        d0 = done_cnt;
        pulse_start();
        repeat (10) cyc();
        i_amp = 11'd300;
        wait_xfers(N + 4, 400, "t3_wait");
        chk("t3_no_done_yet", done_cnt - d0, 0);
        i_cont = 0;
        wait_done(400, "t3_done");
        chk("t3_count", xq.size(), 2 * N);
        if (xq.size() == 2 * N) begin
            chk("t3_first", xq[0], 50);
            chk("t3_f1_124", xq[124], -50);
            chk("t3_f1_125", xq[125], 0);
            chk("t3_f2_0", xq[126], 300);
            chk("t3_f2_3", xq[129], -300);
        end
        chk("t3_done_cnt", done_cnt - d0, 1);
        clear_q();

        // Full-scale amplitude
        i_amp = 11'd2047;
        rnd_ready = 1;
        pulse_start();
        wait_done(3000, "t4_done");
        rnd_ready = 0; i_ready = 1;
        mx = -99999; mn = 99999;
        foreach (xq[k]) begin
            if (xq[k] > mx) mx = xq[k];
            if (xq[k] < mn) mn = xq[k];
        end
        chk("t4_max", mx, 2047);
        chk("t4_min", mn, -2047);
        clear_q();

        // Reset mid-frame, start during RUN ignored
        i_amp = 11'd100;
        pulse_start();
        wait_xfers(20, 200, "t5_w20");
        i_amp = 11'd9;
        pulse_start();
        wait_xfers(40, 200, "t5_w40");
        i_rst = 1;
        cyc();
        i_rst = 0;
        chk("t5_valid", o_valid, 0);
        chk("t5_busy", o_busy, 0);
        chk("t5_last", o_last, 0);
        chk("t5_sample", $signed(o_sample), 0);
        repeat (3) cyc();
        chk("t5_idle_valid", o_valid, 0);
        i_amp = 11'd77;
        pulse_start();
        chk("t5_fresh", $signed(o_sample), 77);
        chk("t5_fresh_valid", o_valid, 1);
        wait_done(400, "t5_done");
        clear_q();

        // Zero amplitude
        i_amp = 11'd0;
        d0 = done_cnt;
        pulse_start();
        wait_done(400, "t6_done");
        chk("t6_count", xq.size(), N);
        if (xq.size() == N) chk("t6_last_pos", lq[N-1], 1);
        chk("t6_done_cnt", done_cnt - d0, 1);
        clear_q();

        // Random soak
        rnd_ready = 1; rnd_cont = 1; rnd_amp = 1; rnd_start = 1;
        repeat (4000) cyc();
        rnd_ready = 0; rnd_cont = 0; rnd_amp = 0; rnd_start = 0;
        i_ready = 1; i_cont = 0; i_start = 0;
        begin : drain
            for (int i = 0; i < 400; i++) begin
                cyc();
                if (o_valid === 1'b0 && o_done === 1'b0) disable drain;
            end
            errs++; checks++;
            $display("FAIL soak_drain: design did not return to idle");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
